// File: rtl/nwc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nwc_pkg
// Description : Shared constants and scheduler state encoding for the
//               nwc core controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package nwc_pkg;

    // Words moved per load/compute/unload job on the nwc core.
    localparam int JOB_WORDS = 2048;

    // Scheduler state encoding.
    localparam int              STATE_W  = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd2;
    localparam logic [STATE_W-1:0] ST_FINISH = 3'd3;
    localparam logic [STATE_W-1:0] ST_ABORT  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_RUN    = ST_RUN,
        S_FINISH = ST_FINISH,
        S_ABORT  = ST_ABORT
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/nwc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nwc_rr_arbiter
// Description : Combinational round-robin pick: first set request at or
//               after the pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module nwc_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [REQ_W-1:0]   win_idx,
    output logic               valid
);

    logic [REQ_W-1:0] w_cand;

    // Scan from the pointer upward; the first hit wins and later hits are ignored.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        valid   = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = REQ_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[w_cand]) begin
                valid           = 1'b1;
                win_idx         = w_cand;
                winner[w_cand]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nwc_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nwc_job_scheduler
// Description : Shares one nwc core among NUM_REQ requesters. Round-robin
//               arbitration, single-cycle core start, registered grant/select
//               for BRAM steering, completion detect on the rising edge of the
//               sticky core done level, and a watchdog abort for hung jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module nwc_job_scheduler
    import nwc_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int REQ_W          = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [REQ_W-1:0]   sel,
    output logic [NUM_REQ-1:0] ack,
    output logic               err,
    output logic [REQ_W-1:0]   err_id,
    output logic               core_start,
    input  logic               core_ready,
    input  logic               core_done,
    output logic               busy,
    output logic [CNT_W-1:0]   jobs_done
);

    localparam int               c_wd_w     = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);
    localparam logic [REQ_W-1:0]  c_last_idx = REQ_W'(NUM_REQ - 1);

    sched_state_t       r_state,     w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,     w_grant_nxt;
    logic [REQ_W-1:0]   r_sel,       w_sel_nxt;
    logic [NUM_REQ-1:0] r_ack,       w_ack_nxt;
    logic               r_err,       w_err_nxt;
    logic [REQ_W-1:0]   r_err_id,    w_err_id_nxt;
    logic               r_start,     w_start_nxt;
    logic               r_busy,      w_busy_nxt;
    logic [CNT_W-1:0]   r_jobs_done, w_jobs_nxt;
    logic [REQ_W-1:0]   r_ptr,       w_ptr_nxt;
    logic [c_wd_w-1:0]  r_wd,        w_wd_nxt;
    logic               r_done_q;

    logic [NUM_REQ-1:0] w_arb_winner;
    logic [REQ_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic               w_done_rise;
    logic [REQ_W-1:0]   w_ptr_after;

    nwc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .winner  (w_arb_winner),
        .win_idx (w_arb_idx),
        .valid   (w_arb_valid)
    );

    // Done is sticky across jobs, so only a fresh rising edge means completion.
    assign w_done_rise = core_done & ~r_done_q;
    assign w_ptr_after = (r_sel == c_last_idx) ? '0 : r_sel + 1'b1;

    // Next-state and next-output decode; every registered output is computed here.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_sel_nxt    = r_sel;
        w_ack_nxt    = '0;
        w_err_nxt    = 1'b0;
        w_err_id_nxt = r_err_id;
        w_start_nxt  = 1'b0;
        w_jobs_nxt   = r_jobs_done;
        w_ptr_nxt    = r_ptr;
        w_wd_nxt     = r_wd;
        case (r_state)
            S_IDLE: begin
                if (w_arb_valid && core_ready) begin
                    w_state_nxt = S_START;
                    w_grant_nxt = w_arb_winner;
                    w_sel_nxt   = w_arb_idx;
                    w_start_nxt = 1'b1;
                end
            end
            S_START: begin
                w_wd_nxt    = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_wd_nxt = r_wd + 1'b1;
                // Completion takes priority over a simultaneous timeout.
                if (w_done_rise) begin
                    w_state_nxt = S_FINISH;
                    w_ack_nxt   = r_grant;
                    w_jobs_nxt  = r_jobs_done + 1'b1;
                    w_ptr_nxt   = w_ptr_after;
                end else if (r_wd == c_wd_last) begin
                    w_state_nxt  = S_ABORT;
                    w_err_nxt    = 1'b1;
                    w_err_id_nxt = r_sel;
                    w_ptr_nxt    = w_ptr_after;
                end
            end
            S_FINISH, S_ABORT: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_sel_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_sel_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset clears everything without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_sel       <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_err_id    <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_jobs_done <= '0;
            r_ptr       <= '0;
            r_wd        <= '0;
            r_done_q    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_sel       <= w_sel_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_err_id    <= w_err_id_nxt;
            r_start     <= w_start_nxt;
            r_busy      <= w_busy_nxt;
            r_jobs_done <= w_jobs_nxt;
            r_ptr       <= w_ptr_nxt;
            r_wd        <= w_wd_nxt;
            r_done_q    <= core_done;
        end
    end

    assign grant      = r_grant;
    assign sel        = r_sel;
    assign ack        = r_ack;
    assign err        = r_err;
    assign err_id     = r_err_id;
    assign core_start = r_start;
    assign busy       = r_busy;
    assign jobs_done  = r_jobs_done;

endmodule
`default_nettype wire

// File: tb/tb_nwc_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nwc_job_scheduler
// Description : Self-checking bench for nwc_job_scheduler with a job-level
//               reference model (round-robin pick, completion/abort timing).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nwc_job_scheduler;

    localparam int NUM_REQ = 4;
    localparam int REQ_W   = 2;
    localparam int TIMEOUT = 48;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] grant;
    logic [REQ_W-1:0]   sel;
    logic [NUM_REQ-1:0] ack;
    logic               err;
    logic [REQ_W-1:0]   err_id;
    logic               core_start;
    logic               core_ready = 1'b1;
    logic               core_done = 1'b0;
    logic               busy;
    logic [CNT_W-1:0]   jobs_done;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_ptr    = 0;
    int m_jobs   = 0;
    int m_err_id = 0;

    nwc_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .REQ_W          (REQ_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .sel        (sel),
        .ack        (ack),
        .err        (err),
        .err_id     (err_id),
        .core_start (core_start),
        .core_ready (core_ready),
        .core_done  (core_done),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "global timeout");
    end

    // First set request at or after p, wrapping around.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        req        = '0;
        core_ready = 1'b1;
        core_done  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_jobs   = 0;
        m_err_id = 0;
    endtask

    // One complete job. Caller is at a negedge with the DUT idle and req set.
    // Core done is driven relative to the start cycle: rises at d_hi (0 = never);
    // if sticky, done begins high and falls at d_lo (0 = never falls).
    task automatic run_job(input int d_hi, input bit sticky, input int d_lo,
                           input bit drop_req, input bit mangle_req);
        int                 exp_o;
        int                 n;
        int                 ev;
        bit                 exp_ack;
        bit                 ok;
        logic [NUM_REQ-1:0] exp_g;
        exp_o = rr_pick(req, m_ptr);
        exp_g = '0;
        if (exp_o >= 0) exp_g[exp_o] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (core_start !== 1'b1 && n < 30);
        total++;
        if (core_start !== 1'b1) begin
            bad++;
            $display("FAIL start_wait: core_start=%b after %0d cycles, want 1", core_start, n);
            return;
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL start_latency: got %0d cycles, want 1", n);
        end
        total++;
        if (grant !== exp_g || sel !== REQ_W'(exp_o) || busy !== 1'b1) begin
            bad++;
            $display("FAIL grant: grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=1",
                     grant, sel, busy, exp_g, exp_o);
        end
        if (!sticky) core_done = 1'b0;
        exp_ack = (d_hi >= 1) && (d_hi <= TIMEOUT);
        ev      = exp_ack ? d_hi + 1 : TIMEOUT + 1;
        ok      = 1'b1;
        for (int k = 1; k < ev; k++) begin
            @(negedge clk);
            if (ack !== '0 || err !== 1'b0 || core_start !== 1'b0 ||
                grant !== exp_g || sel !== REQ_W'(exp_o) || busy !== 1'b1) ok = 1'b0;
            if (sticky && k == d_lo) core_done = 1'b0;
            if (k == d_hi) core_done = 1'b1;
            if (mangle_req && k == 2) req = NUM_REQ'($urandom);
        end
        @(negedge clk);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL job_hold: early ack/err or unstable grant while running owner %0d", exp_o);
        end
        m_ptr = (exp_o + 1) % NUM_REQ;
        if (exp_ack) m_jobs++;
        else m_err_id = exp_o;
        total++;
        if (exp_ack) begin
            if (ack !== exp_g || err !== 1'b0) begin
                bad++;
                $display("FAIL ack: ack=%b err=%b, want ack=%b err=0", ack, err, exp_g);
            end
        end else begin
            if (err !== 1'b1 || err_id !== REQ_W'(exp_o) || ack !== '0) begin
                bad++;
                $display("FAIL abort: err=%b err_id=%0d ack=%b, want err=1 err_id=%0d ack=0",
                         err, err_id, ack, exp_o);
            end
        end
        total++;
        if (jobs_done !== CNT_W'(m_jobs)) begin
            bad++;
            $display("FAIL jobs_done: got %0d, want %0d", jobs_done, m_jobs);
        end
        if (drop_req) req[exp_o] = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== '0 || busy !== 1'b0 || ack !== '0 || err !== 1'b0 ||
            err_id !== REQ_W'(m_err_id)) begin
            bad++;
            $display("FAIL idle_gap: grant=%b busy=%b ack=%b err=%b err_id=%0d, want 0/0/0/0/%0d",
                     grant, busy, ack, err, err_id, m_err_id);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (grant !== '0 || sel !== '0 || ack !== '0 || err !== 1'b0 || err_id !== '0 ||
            core_start !== 1'b0 || busy !== 1'b0 || jobs_done !== '0) begin
            bad++;
            $display("FAIL reset: grant=%b sel=%0d ack=%b err=%b err_id=%0d start=%b busy=%b jobs=%0d, want all 0",
                     grant, sel, ack, err, err_id, core_start, busy, jobs_done);
        end
    endtask

    task automatic test_single_job();
        apply_reset();
        req = 4'b0010;
        run_job(40, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_round_robin();
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_job(5 + 3 * i, 1'b0, 0, 1'b0, 1'b0);
        req = '0;
        total++;
        if (m_ptr != 1) begin
            bad++;
            $display("FAIL rr_order: model pointer %0d after five jobs, want 1", m_ptr);
        end
    endtask

    task automatic test_sticky_done();
        apply_reset();
        req = 4'b0100;
        run_job(6, 1'b0, 0, 1'b1, 1'b0);
        req = 4'b0010;
        core_done = 1'b1;
        run_job(20, 1'b1, 5, 1'b1, 1'b0);
        req = 4'b0001;
        run_job(0, 1'b1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_watchdog();
        apply_reset();
        req = 4'b0011;
        run_job(0, 1'b0, 0, 1'b1, 1'b0);
        run_job(8, 1'b0, 0, 1'b1, 1'b0);
        req = 4'b1000;
        run_job(TIMEOUT, 1'b0, 0, 1'b1, 1'b0);
        req = 4'b1000;
        run_job(TIMEOUT + 1, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_not_ready();
        bit ok;
        apply_reset();
        req        = 4'b0001;
        core_ready = 1'b0;
        ok         = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core_start !== 1'b0 || grant !== '0 || busy !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL not_ready: start=%b grant=%b busy=%b while core not ready, want 0",
                     core_start, grant, busy);
        end
        core_ready = 1'b1;
        run_job(10, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int  d_hi;
        int  d_lo;
        bit  sticky;
        apply_reset();
        for (int j = 0; j < 24; j++) begin
            req    = NUM_REQ'($urandom_range(1, 15));
            d_hi   = $urandom_range(1, TIMEOUT + 3);
            sticky = ($urandom_range(0, 1) == 1) && (d_hi >= 3);
            d_lo   = sticky ? $urandom_range(1, d_hi - 1) : 0;
            if (sticky) core_done = 1'b1;
            run_job(d_hi, sticky, d_lo, 1'b1, 1'b1);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        req = 4'b0100;
        run_job(5, 1'b0, 0, 1'b1, 1'b0);
        req = 4'b1000;
        core_done = 1'b0;
        repeat (7) @(negedge clk);
        total++;
        if (busy !== 1'b1 || grant !== 4'b1000 || jobs_done !== CNT_W'(1)) begin
            bad++;
            $display("FAIL pre_reset: busy=%b grant=%b jobs=%0d, want 1/1000/1", busy, grant, jobs_done);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (grant !== '0 || sel !== '0 || ack !== '0 || busy !== 1'b0 ||
            jobs_done !== '0 || core_start !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: grant=%b sel=%0d ack=%b busy=%b jobs=%0d, want all 0",
                     grant, sel, ack, busy, jobs_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_sticky_done();
        test_watchdog();
        test_not_ready();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
